// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-side arbiter and its helper blocks.
// Also intended for the write-side arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic MST_IM = 1'b0;   // instruction fetch master
  localparam logic MST_DM = 1'b1;   // data access master

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int MST_ID_W = 4;
  localparam int ID_PFX_W = 4;
  localparam int SLV_ID_W = MST_ID_W + ID_PFX_W;

endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick. Purely combinational; the caller owns the
// last_grant register.
module rr_arbiter2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant       = (req == 2'b11) ? ~last_grant : req[MST_DM];
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI read arbiter. One transaction is in flight at a
// time; the grant is held from AR acceptance until the RLAST beat completes.
//
// state | meaning
// IDLE  | no grant held
// ADDR  | granted AR being forwarded to the slave
// DATA  | R burst in flight, routed to the granted master
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ID_W   = MST_ID_W,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,

  input  logic [ID_W-1:0]          M0_ARID,
  input  logic [ADDR_W-1:0]        M0_ARADDR,
  input  logic [LEN_W-1:0]         M0_ARLEN,
  input  logic [2:0]               M0_ARSIZE,
  input  logic [1:0]               M0_ARBURST,
  input  logic                     M0_ARVALID,
  output logic                     M0_ARREADY,
  output logic [ID_W-1:0]          M0_RID,
  output logic [DATA_W-1:0]        M0_RDATA,
  output logic [1:0]               M0_RRESP,
  output logic                     M0_RLAST,
  output logic                     M0_RVALID,
  input  logic                     M0_RREADY,

  input  logic [ID_W-1:0]          M1_ARID,
  input  logic [ADDR_W-1:0]        M1_ARADDR,
  input  logic [LEN_W-1:0]         M1_ARLEN,
  input  logic [2:0]               M1_ARSIZE,
  input  logic [1:0]               M1_ARBURST,
  input  logic                     M1_ARVALID,
  output logic                     M1_ARREADY,
  output logic [ID_W-1:0]          M1_RID,
  output logic [DATA_W-1:0]        M1_RDATA,
  output logic [1:0]               M1_RRESP,
  output logic                     M1_RLAST,
  output logic                     M1_RVALID,
  input  logic                     M1_RREADY,

  output logic [ID_W+ID_PFX_W-1:0] S_ARID,
  output logic [ADDR_W-1:0]        S_ARADDR,
  output logic [LEN_W-1:0]         S_ARLEN,
  output logic [2:0]               S_ARSIZE,
  output logic [1:0]               S_ARBURST,
  output logic                     S_ARVALID,
  input  logic                     S_ARREADY,
  input  logic [ID_W+ID_PFX_W-1:0] S_RID,
  input  logic [DATA_W-1:0]        S_RDATA,
  input  logic [1:0]               S_RRESP,
  input  logic                     S_RLAST,
  input  logic                     S_RVALID,
  output logic                     S_RREADY,

  output logic                     busy
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       arb_grant, arb_valid;
  logic       unused_rid_hi;

  // Upper S_RID bits carry the master index but routing trusts grant_q only.
  assign unused_rid_hi = ^S_RID[ID_W+ID_PFX_W-1:ID_W];

  rr_arbiter2 u_rr (
    .req         ({M1_ARVALID, M0_ARVALID}),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      grant_q      <= MST_IM;
      last_grant_q <= MST_DM;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    busy         = (state_q != IDLE);
    S_ARVALID    = 1'b0;
    S_ARID       = '0;
    S_ARADDR     = '0;
    S_ARLEN      = '0;
    S_ARSIZE     = '0;
    S_ARBURST    = '0;
    S_RREADY     = 1'b0;
    M0_ARREADY   = 1'b0;
    M1_ARREADY   = 1'b0;
    M0_RVALID    = 1'b0;
    M0_RID       = '0;
    M0_RDATA     = '0;
    M0_RRESP     = '0;
    M0_RLAST     = 1'b0;
    M1_RVALID    = 1'b0;
    M1_RID       = '0;
    M1_RDATA     = '0;
    M1_RRESP     = '0;
    M1_RLAST     = 1'b0;

    case (state_q)
      IDLE: begin
        // Registered grant keeps ARVALID off any comb path to S_ARVALID.
        if (arb_valid) begin
          grant_d = arb_grant;
          state_d = ADDR;
        end
      end
      ADDR: begin
        S_ARVALID = 1'b1;
        if (grant_q == MST_DM) begin
          S_ARID     = {ID_PFX_W'(grant_q), M1_ARID};
          S_ARADDR   = M1_ARADDR;
          S_ARLEN    = M1_ARLEN;
          S_ARSIZE   = M1_ARSIZE;
          S_ARBURST  = M1_ARBURST;
          M1_ARREADY = S_ARREADY;
        end else begin
          S_ARID     = {ID_PFX_W'(grant_q), M0_ARID};
          S_ARADDR   = M0_ARADDR;
          S_ARLEN    = M0_ARLEN;
          S_ARSIZE   = M0_ARSIZE;
          S_ARBURST  = M0_ARBURST;
          M0_ARREADY = S_ARREADY;
        end
        if (S_ARREADY) state_d = DATA;
      end
      DATA: begin
        if (grant_q == MST_DM) begin
          S_RREADY  = M1_RREADY;
          M1_RVALID = S_RVALID;
          M1_RID    = S_RID[ID_W-1:0];
          M1_RDATA  = S_RDATA;
          M1_RRESP  = S_RRESP;
          M1_RLAST  = S_RLAST;
        end else begin
          S_RREADY  = M0_RREADY;
          M0_RVALID = S_RVALID;
          M0_RID    = S_RID[ID_W-1:0];
          M0_RDATA  = S_RDATA;
          M0_RRESP  = S_RRESP;
          M0_RLAST  = S_RLAST;
        end
        // Beat count is not tracked; RLAST alone closes the burst.
        if (S_RVALID && S_RREADY && S_RLAST) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI read-channel arbiter. It shares a single read-only memory slave (boot ROM wrapper) between master 0 (instruction fetch) and master 1 (data access).
- Accepts AR requests from both masters and grants one at a time using round-robin.
- Forwards the granted AR to the slave, then routes the whole R burst back to the granted master.
- Holds the grant until RLAST completes, so only one transaction is outstanding.

Parameters:
- ID_W, 4: master-side ID width. Slave-side ID width is ID_W+4.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- LEN_W, 4: burst length width.

Ports:
- ACLK  in  1  clock. Reset ARESETn is asynchronous, active-low; clock ACLK.
- ARESETn  in  1  asynchronous active-low reset.
- Mn_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/LEN_W/3/2  AR payload from master n, for n=0,1.
- Mn_ARVALID  in  1; Mn_ARREADY  out  1: AR handshake, master n.
- Mn_RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  R payload to master n.
- Mn_RVALID  out  1; Mn_RREADY  in  1: R handshake, master n.
- S_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  ID_W+4/ADDR_W/LEN_W/3/2  AR payload to the slave.
- S_ARVALID  out  1; S_ARREADY  in  1: slave AR handshake.
- S_RID/RDATA/RRESP/RLAST  in  ID_W+4/DATA_W/2/1  R payload from the slave.
- S_RVALID  in  1; S_RREADY  out  1: slave R handshake.
- busy  out  1: high whenever state is not IDLE.

Behaviour:
- States:
  - IDLE: no grant held.
  - ADDR: granted AR is being forwarded.
  - DATA: R burst is in flight.
- Registers:
  - state.
  - grant (1 bit).
  - last_grant (1 bit). Reset value is 1, so M0 wins the first tie.
- Reset outputs: S_ARVALID=0, S_RREADY=0, Mn_ARREADY=0, Mn_RVALID=0, busy=0. All payload outputs are 0.
- IDLE:
  - If exactly one Mn_ARVALID is high, set grant=n.
  - If both are high, set grant=~last_grant.
  - Go to ADDR next cycle. No combinational valid-to-valid path: S_ARVALID rises one cycle after the request is sampled.
- ADDR:
  - S_ARVALID=1. S_AR payload is a combinational mux of the granted master's AR.
  - S_ARID={4'(grant), M_ARID}.
  - M[grant]_ARREADY=S_ARREADY. The other master's ARREADY=0.
  - On S_ARVALID&S_ARREADY, go to DATA.
- DATA:
  - M[grant]_RVALID=S_RVALID and S_RREADY=M[grant]_RREADY.
  - R payload goes to the granted master. M_RID=S_RID[ID_W-1:0].
  - The non-granted master sees RVALID=0 and payload 0.
  - On S_RVALID&S_RREADY&S_RLAST: go to IDLE and set last_grant<=grant.
- Minimum idle gap between bursts is 1 cycle (IDLE state). Back-to-back requests alternate masters.
- Routing is by grant only. S_RID upper bits are not checked; a mismatch is ignored.
- A master that drops ARVALID in ADDR before the handshake violates AXI. The arbiter keeps forwarding the held mux value anyway; the bench flags this.
- Burst length is not counted: RLAST alone terminates DATA.
- S_RVALID seen in IDLE or ADDR is not acknowledged (S_RREADY=0).
- Reset mid-transaction: immediately return to IDLE, last_grant=1, all handshake outputs 0. The in-flight burst is abandoned; the slave is reset by the same ARESETn.
- M_RRESP passes S_RRESP through unchanged (OKAY=2'b00 from the ROM).

Decomposition:
- Shared AXI package holds:
  - typedef arb_state_e {IDLE, ADDR, DATA}.
  - Master index constants MST_IM=0, MST_DM=1.
  - AXI_RESP_OKAY.
  - Master/slave ID width constants.
- One natural sub-module: rr_arbiter2. It is purely combinational and takes req[1:0] and last_grant to produce grant and grant_valid. Reuse it later for the write-side arbiter.

Test Plan:
- Single request: M0_ARVALID=1, ARADDR=0x0000_0010, ARLEN=3, ARID=4'h2. S_ARVALID rises on cycle 1 with S_ARID=8'h02. After the handshake, 4 beats reach M0 with RLAST on beat 4. M1_RVALID stays 0 throughout; busy drops one cycle after the final beat.
- Simultaneous requests after reset: M0 and M1 assert together with LEN=0. M0 is served first, then M1. S_ARID upper nibble is 0 then 1. Exactly 1 IDLE cycle separates the two bursts.
- Fairness: both masters hold requests continuously for 6 transactions. Grants go M0,M1,M0,M1,M0,M1 with no starvation.
- Backpressure:
  - Slave holds S_ARREADY=0 for 5 cycles; M0_ARREADY stays 0 and S_AR payload stays stable.
  - M0_RREADY toggles 1,0,1,0 during a LEN=1 burst; S_RREADY mirrors it each cycle and no beat is lost or duplicated.
- Late requester: M1 requests while M0 is in DATA. M1_ARREADY stays 0 until M0's RLAST completes; M1 is granted in the following IDLE.
- Reset mid-burst: deassert ARESETn during beat 2 of a LEN=3 burst. All outputs go to 0 asynchronously. After release, an M0+M1 simultaneous request grants M0.
